engagement_sequencer: RTL and testbench

//  Downstream of the ICMS top. Consumes safe_to_engage, threat_detected,

---
 rtl/engagement_sequencer.sv | 165 ++++++++++++++++
 tb/tb_engagement_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/engagement_sequencer.sv
// Weapon engagement sequencer: lock-on qualification, armed/fire/cooldown cycle,
// round accounting and emergency abort to a safe state.
module engagement_sequencer #(
    parameter int unsigned LOCK_CYCLES     = 4,
    parameter int unsigned COOLDOWN_CYCLES = 8,
    parameter int unsigned MAX_ROUNDS      = 6,
    parameter logic [31:0] MIN_RANGE       = 32'd100,
    parameter logic [31:0] FIRE_RANGE      = 32'd2000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        safe_to_engage,
    input  logic        threat_detected,
    input  logic [31:0] distance_to_target,
    input  logic        emergency_landing_alert,
    input  logic        fire_cmd,
    input  logic        reload,
    output logic        weapon_armed,
    output logic        fire_pulse,
    output logic        lock_acquired,
    output logic        abort_active,
    output logic [7:0]  rounds_remaining,
    output logic [2:0]  engage_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_TRACK    = 3'd1;
    localparam logic [2:0] S_ARMED    = 3'd2;
    localparam logic [2:0] S_FIRE     = 3'd3;
    localparam logic [2:0] S_COOLDOWN = 3'd4;
    localparam logic [2:0] S_SAFE     = 3'd5;

    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int COOL_W = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [COOL_W-1:0] COOL_LAST  = COOL_W'(COOLDOWN_CYCLES - 1);
    localparam logic [7:0]        ROUNDS_MAX = 8'(MAX_ROUNDS);

    logic [2:0]        r_state;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic [COOL_W-1:0] r_cool_cnt;
    logic [7:0]        r_rounds;

    logic [2:0]        w_state_nxt;
    logic [LOCK_W-1:0] w_lock_nxt;
    logic [COOL_W-1:0] w_cool_nxt;
    logic [7:0]        w_rounds_nxt;
    logic              w_in_window;

    assign w_in_window = safe_to_engage &&
                         (distance_to_target >= MIN_RANGE) &&
                         (distance_to_target <= FIRE_RANGE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_lock_cnt <= '0;
            r_cool_cnt <= '0;
            r_rounds   <= ROUNDS_MAX;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_nxt;
            r_cool_cnt <= w_cool_nxt;
            r_rounds   <= w_rounds_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_lock_nxt   = r_lock_cnt;
        w_cool_nxt   = r_cool_cnt;
        w_rounds_nxt = r_rounds;
        case (r_state)
            S_IDLE: begin
                // A same-edge reload counts toward the non-empty check for TRACK.
                if (reload) w_rounds_nxt = ROUNDS_MAX;
                if (threat_detected && (w_rounds_nxt != 8'd0)) begin
                    w_state_nxt = S_TRACK;
                    w_lock_nxt  = '0;
                end
            end
            S_TRACK: begin
                if (!threat_detected) begin
                    w_state_nxt = S_IDLE;
                end else if (w_in_window) begin
                    if (r_lock_cnt == LOCK_LAST) begin
                        w_state_nxt = S_ARMED;
                        w_lock_nxt  = '0;
                    end else begin
                        w_lock_nxt = r_lock_cnt + 1'b1;
                    end
                end else begin
                    w_lock_nxt = '0;
                end
            end
            S_ARMED: begin
                if (!w_in_window || !threat_detected) begin
                    w_state_nxt = S_TRACK;
                    w_lock_nxt  = '0;
                end else if (fire_cmd) begin
                    w_state_nxt = S_FIRE;
                end
            end
            S_FIRE: begin
                w_state_nxt = S_COOLDOWN;
                w_cool_nxt  = '0;
                if (r_rounds != 8'd0) w_rounds_nxt = r_rounds - 8'd1;
            end
            S_COOLDOWN: begin
                if (r_cool_cnt == COOL_LAST) begin
                    w_cool_nxt = '0;
                    if ((r_rounds != 8'd0) && threat_detected) begin
                        w_state_nxt = S_TRACK;
                        w_lock_nxt  = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cool_nxt = r_cool_cnt + 1'b1;
                end
            end
            S_SAFE: begin
                w_lock_nxt = '0;
                w_cool_nxt = '0;
                if (!emergency_landing_alert) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_lock_nxt  = '0;
                w_cool_nxt  = '0;
            end
        endcase
        // Abort wins everywhere; only an in-flight shot keeps its decrement.
        if (emergency_landing_alert) begin
            w_state_nxt = S_SAFE;
            w_lock_nxt  = '0;
            w_cool_nxt  = '0;
            if (r_state != S_FIRE) w_rounds_nxt = r_rounds;
        end
    end

    always_comb begin
        weapon_armed  = 1'b0;
        fire_pulse    = 1'b0;
        lock_acquired = 1'b0;
        abort_active  = 1'b0;
        case (r_state)
            S_ARMED: begin
                weapon_armed  = 1'b1;
                lock_acquired = 1'b1;
            end
            S_FIRE: begin
                fire_pulse    = 1'b1;
                lock_acquired = 1'b1;
            end
            S_COOLDOWN: lock_acquired = 1'b1;
            S_SAFE:     abort_active  = 1'b1;
            default: ;
        endcase
    end

    assign rounds_remaining = r_rounds;
    assign engage_state     = r_state;

endmodule

// File: tb/tb_engagement_sequencer.sv
// Bench for engagement_sequencer: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the engagement rules.
module tb_engagement_sequencer;

    localparam int LOCK   = 4;
    localparam int COOL   = 8;
    localparam int MAXR   = 6;
    localparam int GAP    = 1 + COOL + LOCK + 1;
    localparam int IDLE_S = 0, TRACK_S = 1, ARMED_S = 2, FIRE_S = 3, COOL_S = 4, SAFE_S = 5;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        safe_to_engage = 1'b0;
    logic        threat_detected = 1'b0;
    logic [31:0] distance_to_target = 32'd0;
    logic        emergency_landing_alert = 1'b0;
    logic        fire_cmd = 1'b0;
    logic        reload = 1'b0;
    logic        weapon_armed;
    logic        fire_pulse;
    logic        lock_acquired;
    logic        abort_active;
    logic [7:0]  rounds_remaining;
    logic [2:0]  engage_state;

    engagement_sequencer dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .safe_to_engage          (safe_to_engage),
        .threat_detected         (threat_detected),
        .distance_to_target      (distance_to_target),
        .emergency_landing_alert (emergency_landing_alert),
        .fire_cmd                (fire_cmd),
        .reload                  (reload),
        .weapon_armed            (weapon_armed),
        .fire_pulse              (fire_pulse),
        .lock_acquired           (lock_acquired),
        .abort_active            (abort_active),
        .rounds_remaining        (rounds_remaining),
        .engage_state            (engage_state)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // Model: state name, consecutive in-window streak, cooldown cycles left, rounds.
    int m_st = IDLE_S;
    int m_streak = 0;
    int m_cool_left = 0;
    int m_rounds = MAXR;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = IDLE_S;
        m_streak = 0;
        m_cool_left = 0;
        m_rounds = MAXR;
    endtask

    task automatic model_step();
        bit inw;
        int ns;
        int nr;
        inw = safe_to_engage && (distance_to_target >= 32'd100) && (distance_to_target <= 32'd2000);
        ns = m_st;
        nr = m_rounds;
        if (m_st == FIRE_S) nr = (m_rounds > 0) ? m_rounds - 1 : 0;
        if (emergency_landing_alert) begin
            ns = SAFE_S;
        end else begin
            case (m_st)
                IDLE_S: begin
                    if (reload) nr = MAXR;
                    if (threat_detected && nr > 0) begin ns = TRACK_S; m_streak = 0; end
                end
                TRACK_S: begin
                    if (!threat_detected) ns = IDLE_S;
                    else if (!inw) m_streak = 0;
                    else begin
                        m_streak++;
                        if (m_streak >= LOCK) ns = ARMED_S;
                    end
                end
                ARMED_S: begin
                    if (!(inw && threat_detected)) begin ns = TRACK_S; m_streak = 0; end
                    else if (fire_cmd) ns = FIRE_S;
                end
                FIRE_S: begin ns = COOL_S; m_cool_left = COOL; end
                COOL_S: begin
                    m_cool_left--;
                    if (m_cool_left == 0) begin
                        if (nr > 0 && threat_detected) begin ns = TRACK_S; m_streak = 0; end
                        else ns = IDLE_S;
                    end
                end
                default: ns = IDLE_S;
            endcase
        end
        m_st = ns;
        m_rounds = nr;
    endtask

    function automatic logic [31:0] exp_outs();
        logic [31:0] v;
        v = '0;
        v[15] = (m_st == SAFE_S);
        v[14] = (m_st == ARMED_S) || (m_st == FIRE_S) || (m_st == COOL_S);
        v[13] = (m_st == FIRE_S);
        v[12] = (m_st == ARMED_S);
        v[10:8] = m_st[2:0];
        v[7:0] = m_rounds[7:0];
        return v;
    endfunction

    function automatic logic [31:0] dut_outs();
        return {16'd0, abort_active, lock_acquired, fire_pulse, weapon_armed,
                1'b0, engage_state, rounds_remaining};
    endfunction

    // Inputs are set at the falling edge before calling; compare at the next falling edge.
    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        chk("cycle_outs", dut_outs(), exp_outs());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        #1 RST = 1'b0;
        #1;
        model_reset();
        chk("rst_state", {29'd0, engage_state}, 32'd0);
        chk("rst_rounds", {24'd0, rounds_remaining}, MAXR);
        chk("rst_flags", {28'd0, abort_active, lock_acquired, fire_pulse, weapon_armed}, 32'd0);
        #1 RST = 1'b1;
    endtask

    task automatic set_dist(input logic [31:0] d);
        distance_to_target = d;
    endtask

    initial begin
        int last;
        int npulse;
        logic [31:0] dlist[7];

        RST = 1'b0;
        repeat (2) @(negedge CLK);
        model_reset();
        chk("rst_state", {29'd0, engage_state}, 32'd0);
        chk("rst_rounds", {24'd0, rounds_remaining}, MAXR);
        chk("rst_flags", {28'd0, abort_active, lock_acquired, fire_pulse, weapon_armed}, 32'd0);
        RST = 1'b1;

        // Lock-on and arm.
        threat_detected = 1; safe_to_engage = 1; set_dist(32'd1500);
        tick();
        chk("t1_track", {29'd0, engage_state}, TRACK_S);
        ticks(LOCK - 1);
        chk("t1_not_yet", {29'd0, engage_state}, TRACK_S);
        tick();
        chk("t1_armed", {29'd0, engage_state}, ARMED_S);
        chk("t1_weapon_armed", {31'd0, weapon_armed}, 1);
        chk("t1_rounds", {24'd0, rounds_remaining}, 6);

        // Single shot then cooldown and relock.
        fire_cmd = 1;
        tick();
        chk("t2_pulse", {31'd0, fire_pulse}, 1);
        fire_cmd = 0;
        tick();
        chk("t2_pulse_off", {31'd0, fire_pulse}, 0);
        chk("t2_rounds", {24'd0, rounds_remaining}, 5);
        ticks(COOL - 1);
        chk("t2_cooldown", {29'd0, engage_state}, COOL_S);
        tick();
        chk("t2_retrack", {29'd0, engage_state}, TRACK_S);

        // Window boundaries break and rebuild the lock streak.
        dlist = '{32'd1500, 32'd1500, 32'd2001, 32'd1500, 32'd1500, 32'd1500, 32'd1500};
        for (int i = 0; i < 7; i++) begin
            set_dist(dlist[i]);
            tick();
            if (i == 5) chk("t3_hi_not_armed", {29'd0, engage_state}, TRACK_S);
        end
        chk("t3_hi_armed", {29'd0, engage_state}, ARMED_S);
        set_dist(32'd99);
        tick();
        chk("t3_drop", {29'd0, engage_state}, TRACK_S);
        dlist = '{32'd1500, 32'd99, 32'd100, 32'd2000, 32'd100, 32'd2000, 32'd2000};
        for (int i = 0; i < 7; i++) begin
            set_dist(dlist[i]);
            tick();
            if (i == 4) chk("t3_lo_not_armed", {29'd0, engage_state}, TRACK_S);
        end
        chk("t3_lo_armed", {29'd0, engage_state}, ARMED_S);

        // Emergency alert from TRACK, ARMED and FIRE.
        set_dist(32'd2001);
        tick();
        emergency_landing_alert = 1; set_dist(32'd1500);
        tick();
        chk("t4_safe_track", {31'd0, abort_active}, 1);
        emergency_landing_alert = 0;
        tick();
        chk("t4_idle1", {29'd0, engage_state}, IDLE_S);
        ticks(1 + LOCK);
        chk("t4_armed", {29'd0, engage_state}, ARMED_S);
        emergency_landing_alert = 1;
        tick();
        chk("t4_safe_armed", {29'd0, engage_state}, SAFE_S);
        emergency_landing_alert = 0;
        ticks(2 + LOCK);
        fire_cmd = 1;
        tick();
        chk("t4_fire", {29'd0, engage_state}, FIRE_S);
        fire_cmd = 0; emergency_landing_alert = 1;
        tick();
        chk("t4_safe_fire", {29'd0, engage_state}, SAFE_S);
        chk("t4_fire_decrement", {24'd0, rounds_remaining}, 4);
        emergency_landing_alert = 0; threat_detected = 0;
        tick();
        chk("t4_idle2", {29'd0, engage_state}, IDLE_S);

        // Empty the magazine with fire held, then reload.
        reload = 1;
        tick();
        chk("t5_reload", {24'd0, rounds_remaining}, 6);
        reload = 0; threat_detected = 1; fire_cmd = 1;
        last = -1; npulse = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (fire_pulse) begin
                if (last >= 0) chk("t5_gap", i - last, GAP);
                last = i;
                npulse++;
            end
        end
        chk("t5_shots", npulse, 6);
        chk("t5_empty", {24'd0, rounds_remaining}, 0);
        chk("t5_stay_idle", {29'd0, engage_state}, IDLE_S);
        fire_cmd = 0; reload = 1;
        tick();
        chk("t5_resume", {29'd0, engage_state}, TRACK_S);
        chk("t5_full", {24'd0, rounds_remaining}, 6);
        reload = 0;

        // Reset in FIRE and in COOLDOWN.
        ticks(LOCK);
        fire_cmd = 1;
        tick();
        chk("t6_in_fire", {29'd0, engage_state}, FIRE_S);
        fire_cmd = 0;
        do_reset();
        ticks(1 + LOCK);
        fire_cmd = 1;
        tick();
        fire_cmd = 0;
        ticks(3);
        chk("t6_in_cool", {29'd0, engage_state}, COOL_S);
        do_reset();

        // Illegal state code recovers to IDLE.
        threat_detected = 0;
        force dut.r_state = 3'd6;
        #1;
        chk("t6_forced", {29'd0, engage_state}, 6);
        #1 release dut.r_state;
        tick();
        chk("t6_recover", {29'd0, engage_state}, IDLE_S);

        // Randomized traffic.
        for (int c = 0; c < 2500; c++) begin
            case ($urandom_range(0, 9))
                0: set_dist(32'd99);
                1: set_dist(32'd100);
                2: set_dist(32'd2000);
                3: set_dist(32'd2001);
                4: set_dist(32'd0);
                5: set_dist(32'hFFFF_FFFF);
                6: set_dist($urandom);
                default: set_dist($urandom_range(100, 2000));
            endcase
            threat_detected = ($urandom_range(0, 9) != 0);
            safe_to_engage = ($urandom_range(0, 9) != 0);
            emergency_landing_alert = ($urandom_range(0, 39) == 0);
            reload = ($urandom_range(0, 19) == 0);
            fire_cmd = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 199) == 0) do_reset();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
